// File: rtl/spram_pkg.sv
// Shared widths, write mask and command-state encoding for the SPRAM arbiter.
package spram_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    localparam logic [3:0] MASK_ALL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

endpackage

// File: rtl/spram_arbiter.sv
// Two-requester arbiter for a single-port SPRAM: one posted write buffer,
// one outstanding read, round-robin grant with write-first on address match.
module spram_arbiter #(
    parameter int ADDR_W = spram_pkg::ADDR_W,
    parameter int DATA_W = spram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_strobe,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_strobe,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    output logic [3:0]        ram_maskwren,
    input  logic [DATA_W-1:0] ram_rdata
);
    import spram_pkg::*;

    state_e            state_q, state_d;
    logic              wr_pending_q, wr_pending_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_pending_q, rd_pending_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              last_wr_q, last_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              rd_cap_q, rd_cap_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic wr_accept;
    logic rd_accept;
    logic grant_wr;
    logic grant_rd;

    always_comb begin
        wr_ready = !wr_pending_q;
        // Read side stays busy through the SPRAM sample and capture cycles.
        rd_ready = !rd_pending_q && (state_q != READ) && !rd_cap_q;

        wr_accept = wr_strobe && wr_ready;
        rd_accept = rd_strobe && rd_ready;

        grant_wr = wr_pending_q &&
                   (!rd_pending_q || (wr_addr_q == rd_addr_q) || !last_wr_q);
        grant_rd = rd_pending_q && !grant_wr;

        state_d      = IDLE;
        wr_pending_d = wr_pending_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_pending_d = rd_pending_q;
        rd_addr_d    = rd_addr_q;
        last_wr_d    = last_wr_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;

        if (grant_wr) begin
            state_d      = WRITE;
            wr_pending_d = 1'b0;
            last_wr_d    = 1'b1;
            ram_addr_d   = wr_addr_q;
            ram_wdata_d  = wr_data_q;
        end else if (grant_rd) begin
            state_d      = READ;
            rd_pending_d = 1'b0;
            last_wr_d    = 1'b0;
            ram_addr_d   = rd_addr_q;
        end

        if (wr_accept) begin
            wr_pending_d = 1'b1;
            wr_addr_d    = wr_addr;
            wr_data_d    = wr_data;
        end
        if (rd_accept) begin
            rd_pending_d = 1'b1;
            rd_addr_d    = rd_addr;
        end

        rd_cap_d   = (state_q == READ);
        rd_valid_d = rd_cap_q;
        rd_data_d  = rd_cap_q ? ram_rdata : rd_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_pending_q <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_pending_q <= 1'b0;
            rd_addr_q    <= '0;
            last_wr_q    <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            rd_cap_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_pending_q <= wr_pending_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_pending_q <= rd_pending_d;
            rd_addr_q    <= rd_addr_d;
            last_wr_q    <= last_wr_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            rd_cap_q     <= rd_cap_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign ram_wren     = (state_q == WRITE);
    assign ram_maskwren = (state_q == WRITE) ? MASK_ALL : '0;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: transaction-level reference model,
// behavioural SPRAM, directed scenarios plus randomized traffic.
module tb_spram_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_strobe = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_strobe = 1'b0;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wren;
    logic [3:0]    ram_maskwren;
    logic [DW-1:0] ram_rdata = '0;

    always #5 clk = ~clk;

    spram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strobe(wr_strobe), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_strobe(rd_strobe), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
        .ram_maskwren(ram_maskwren), .ram_rdata(ram_rdata)
    );

    // Behavioural SPRAM: write when enabled, otherwise registered read.
    logic [DW-1:0] mem  [0:DEPTH-1];
    logic [DW-1:0] gold [0:DEPTH-1];

    always @(posedge clk) begin
        if (ram_wren && ram_maskwren == 4'hF) mem[ram_addr] <= ram_wdata;
        else                                  ram_rdata     <= mem[ram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending write, one pending read, results due at a cycle.
    int            cyc;
    logic          m_wp, m_rp, m_last_w, m_rd_out;
    logic [AW-1:0] m_waddr, m_raddr, m_addr;
    logic [DW-1:0] m_wdata, m_wd_out, m_rdexp, e_rdata;
    int            m_due;
    logic          e_wren, e_valid;
    logic          pw, pr, gw, gr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0; m_wp = 0; m_rp = 0; m_last_w = 0; m_rd_out = 0;
            m_waddr = '0; m_raddr = '0; m_addr = '0; m_wdata = '0; m_wd_out = '0;
            m_rdexp = '0; e_rdata = '0; m_due = 0; e_wren = 0; e_valid = 0;
        end else begin
            cyc++;
            pw = !m_wp;
            pr = !m_rp && !m_rd_out;
            e_valid = 0;
            if (m_rd_out && cyc == m_due) begin
                e_valid = 1; e_rdata = m_rdexp; m_rd_out = 0;
            end
            gw = m_wp && (!m_rp || m_waddr == m_raddr || !m_last_w);
            gr = m_rp && !gw;
            e_wren = gw;
            if (gw) begin
                gold[m_waddr] = m_wdata;
                m_addr = m_waddr; m_wd_out = m_wdata; m_wp = 0; m_last_w = 1;
            end
            if (gr) begin
                m_rdexp = gold[m_raddr];
                m_addr = m_raddr; m_rp = 0; m_last_w = 0;
                m_rd_out = 1; m_due = cyc + 2;
            end
            if (wr_strobe && pw) begin m_wp = 1; m_waddr = wr_addr; m_wdata = wr_data; end
            if (rd_strobe && pr) begin m_rp = 1; m_raddr = rd_addr; end
        end
    end

    int wr_low = 0;
    int rd_low = 0;

    always @(negedge clk) begin
        if (reset) begin
            wr_low = 0; rd_low = 0;
        end else begin
            chk("wr_ready", wr_ready, !m_wp);
            chk("rd_ready", rd_ready, !m_rp && !m_rd_out);
            chk("ram_wren", ram_wren, e_wren);
            chk("ram_maskwren", ram_maskwren, e_wren ? 4'hF : 4'h0);
            chk("ram_addr", ram_addr, m_addr);
            chk("ram_wdata", ram_wdata, m_wd_out);
            chk("rd_valid", rd_valid, e_valid);
            if (e_valid) chk("rd_data", rd_data, e_rdata);
            if (!wr_ready) wr_low++;
            else begin
                if (wr_low > 0) chk("wr_wait_le2", wr_low <= 2, 1);
                wr_low = 0;
            end
            if (!rd_ready) rd_low++;
            else begin
                if (rd_low > 0) chk("rd_wait_le4", rd_low <= 4, 1);
                rd_low = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? 14'h3FFF : AW'($urandom_range(0, 7));
        return a;
    endfunction

    int wren_cnt;
    int valid_cnt;
    logic got;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; gold[i] = '0; end
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ram_wren", ram_wren, 0);
        chk("rst_ram_mask", ram_maskwren, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_wr_ready", wr_ready, 1);
        chk("rel_rd_ready", rd_ready, 1);

        // Write then read back one word.
        wr_addr = 14'h0005; wr_data = 16'h1234; wr_strobe = 1; tick(); wr_strobe = 0;
        chk("t1_wr_ready_low", wr_ready, 0);
        tick();
        chk("t1_wren", ram_wren, 1);
        chk("t1_waddr", ram_addr, 14'h0005);
        chk("t1_wdata", ram_wdata, 16'h1234);
        chk("t1_wmask", ram_maskwren, 4'hF);
        tick();
        chk("t1_wren_off", ram_wren, 0);
        rd_addr = 14'h0005; rd_strobe = 1; tick(); rd_strobe = 0;
        chk("t1_rd_ready_low", rd_ready, 0);
        tick();
        chk("t1_raddr", ram_addr, 14'h0005);
        chk("t1_rmask", ram_maskwren, 0);
        tick();
        chk("t1_valid_early", rd_valid, 0);
        tick();
        chk("t1_valid", rd_valid, 1);
        chk("t1_rd_data", rd_data, 16'h1234);
        tick();
        chk("t1_valid_once", rd_valid, 0);

        // Make the last grant a write, then collide on one address.
        wr_addr = 14'h0011; wr_data = 16'h0000; wr_strobe = 1; tick(); wr_strobe = 0;
        tick(); tick();
        wr_addr = 14'h0010; wr_data = 16'hBEEF; rd_addr = 14'h0010;
        wr_strobe = 1; rd_strobe = 1; tick(); wr_strobe = 0; rd_strobe = 0;
        tick();
        chk("t2_write_first", ram_wren, 1);
        chk("t2_waddr", ram_addr, 14'h0010);
        tick();
        chk("t2_read_second", ram_wren, 0);
        chk("t2_raddr", ram_addr, 14'h0010);
        tick(); tick();
        chk("t2_valid", rd_valid, 1);
        chk("t2_rd_data", rd_data, 16'hBEEF);
        tick(); tick();

        // Last grant was a read: different addresses -> write then read.
        wr_addr = 14'h0030; wr_data = 16'h3030; rd_addr = 14'h0031;
        wr_strobe = 1; rd_strobe = 1; tick(); wr_strobe = 0; rd_strobe = 0;
        tick();
        chk("t3_rr_write", ram_wren, 1);
        tick();
        chk("t3_rr_read_addr", ram_addr, 14'h0031);
        chk("t3_rr_read_wren", ram_wren, 0);
        repeat (4) tick();

        // Repeated write strobe while busy is ignored.
        wr_addr = 14'h0020; wr_data = 16'h1111; wr_strobe = 1; tick();
        wr_addr = 14'h0021; wr_data = 16'h2222; tick(); wr_strobe = 0;
        chk("t4_wren", ram_wren, 1);
        chk("t4_waddr", ram_addr, 14'h0020);
        wren_cnt = 0;
        repeat (4) begin tick(); if (ram_wren) wren_cnt++; end
        chk("t4_no_second_write", wren_cnt, 0);

        // Top word, no wrap.
        wr_addr = 14'h3FFF; wr_data = 16'hA5A5; wr_strobe = 1; tick(); wr_strobe = 0;
        tick();
        chk("t5_top_addr", ram_addr, 14'h3FFF);
        tick();
        rd_addr = 14'h3FFF; rd_strobe = 1; tick(); rd_strobe = 0;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (rd_valid) begin got = 1; chk("t5_top_data", rd_data, 16'hA5A5); end
        end
        chk("t5_valid_seen", got, 1);
        tick();

        // Reset the cycle after a read issues.
        rd_addr = 14'h0005; rd_strobe = 1; tick(); rd_strobe = 0;
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_ram_addr", ram_addr, 0);
        chk("t6_ram_wren", ram_wren, 0);
        chk("t6_rd_data", rd_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_wr_ready", wr_ready, 1);
        chk("t6_rd_ready", rd_ready, 1);
        valid_cnt = 0;
        repeat (6) begin tick(); if (rd_valid) valid_cnt++; end
        chk("t6_no_valid", valid_cnt, 0);

        // Continuous strobing on both sides, distinct addresses.
        for (int i = 0; i < 60; i++) begin
            wr_addr = AW'(2 * $urandom_range(0, 7)); wr_data = DW'($urandom);
            rd_addr = AW'(2 * $urandom_range(0, 7) + 1);
            wr_strobe = 1; rd_strobe = 1;
            tick();
        end

        // Random traffic with frequent address collisions.
        for (int i = 0; i < 500; i++) begin
            wr_addr = pick_addr(); wr_data = DW'($urandom); rd_addr = pick_addr();
            wr_strobe = ($urandom_range(0, 2) != 0);
            rd_strobe = ($urandom_range(0, 1) != 0);
            tick();
        end
        wr_strobe = 0; rd_strobe = 0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
